lsu_data_memory: RTL and testbench

Parametrised byte-addressable data memory with a request/response handshake, sitting between the RV32I load/store path and the register-file writeback mux. It supports all RV32I load/store widths with sign/zero extension, configurable depth and access latency, and detection of misaligned, out-of-range and illegal accesses. A hardware clear sequence zeroes the array after reset.

---
 rtl/lsu_data_memory_pkg.sv | 25 ++
 rtl/lsu_data_memory_if.sv | 26 ++
 rtl/lsu_data_memory_align.sv | 72 +++++++
 rtl/lsu_data_memory.sv | 135 +++++++++++++
 tb/tb_lsu_data_memory.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_data_memory_pkg.sv
// Shared types for the load/store data memory: funct3 codes, error codes and
// the controller states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      OK           = 2'b00,
      MISALIGNED   = 2'b01,
      OUT_OF_RANGE = 2'b10,
      ILLEGAL_OP   = 2'b11
   } lsu_err_t;

   typedef enum logic [1:0] {
      INIT = 2'b00,
      IDLE = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } lsu_state_t;

endpackage

// File: rtl/lsu_data_memory_if.sv
// Request/response bus between the load/store unit and the data memory.
interface lsu_data_memory_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        init_done;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

endinterface

// File: rtl/lsu_data_memory_align.sv
// Lane steering for RV32I loads/stores: byte enables, store replication,
// load extraction with sign/zero extension, and decode fault flags.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        write,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] ldata,
   output logic        misalign,
   output logic        illegal
);

   function automatic logic [31:0] sext8(input logic signed [7:0] b);
      logic signed [31:0] s;
      s = b;
      return s;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] h);
      logic signed [31:0] s;
      s = h;
      return s;
   endfunction

   logic [31:0] shifted;

   always_comb begin
      byte_en   = 4'b0000;
      wdata_rep = wdata;
      ldata     = '0;
      misalign  = 1'b0;
      shifted   = rword >> {addr_lo, 3'b000};

      // Loads leave the 011 slot and the 11x slots unused; stores only define 000..010.
      if (write)
         illegal = (funct3 >= 3'b011);
      else
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);

      case (funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
         end
         default: begin
            byte_en   = 4'b1111;
            wdata_rep = wdata;
            misalign  = (addr_lo != 2'b00);
         end
      endcase

      case (funct3)
         F3_B:    ldata = sext8(shifted[7:0]);
         F3_H:    ldata = sext16(shifted[15:0]);
         F3_W:    ldata = shifted;
         F3_BU:   ldata = {24'h0, shifted[7:0]};
         F3_HU:   ldata = {16'h0, shifted[15:0]};
         default: ldata = '0;
      endcase
   end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressable data memory with a one-outstanding request/response
// handshake, programmable access latency and a post-reset clear sequence.
module lsu_data_memory
   import lsu_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 1
)(
   input logic              clk,
   input logic              reset,
   lsu_data_memory_if.slave bus
);

   localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
   localparam int AW          = $clog2(DEPTH_BYTES);
   localparam int WW          = AW - 2;

   logic [31:0]   mem [DEPTH_WORDS];

   lsu_state_t    state;
   logic [WW-1:0] init_idx;
   logic [3:0]    lat_cnt;
   logic          req_ready_q;
   logic          vld_p1;
   logic [31:0]   rdata_p1;
   lsu_err_t      err_p1;
   logic          init_done_q;

   logic [WW-1:0] widx;
   logic [31:0]   rword;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_rep;
   logic [31:0]   ldata;
   logic          misalign;
   logic          illegal;
   logic          out_of_range;
   lsu_err_t      req_err;
   logic          accept;

   assign widx         = bus.req_addr[AW-1:2];
   assign rword        = mem[widx];
   assign out_of_range = (bus.req_addr >= 32'(DEPTH_BYTES));
   assign accept       = (state == IDLE) && bus.req_valid;

   lsu_align u_align (
      .funct3    (bus.req_funct3),
      .addr_lo   (bus.req_addr[1:0]),
      .write     (bus.req_write),
      .wdata     (bus.req_wdata),
      .rword     (rword),
      .byte_en   (byte_en),
      .wdata_rep (wdata_rep),
      .ldata     (ldata),
      .misalign  (misalign),
      .illegal   (illegal)
   );

   always_comb begin
      req_err = OK;
      if (illegal)
         req_err = ILLEGAL_OP;
      else if (misalign)
         req_err = MISALIGNED;
      else if (out_of_range)
         req_err = OUT_OF_RANGE;
   end

   // Array is cleared by the INIT walk rather than by reset, so it has no reset.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[init_idx] <= '0;
      end else if (accept && bus.req_write && (req_err == OK)) begin
         for (int i = 0; i < 4; i++)
            if (byte_en[i])
               mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
   end

   // Acceptance edge is stage p0; the response registers form stage p1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= INIT;
         init_idx    <= '0;
         lat_cnt     <= '0;
         req_ready_q <= 1'b0;
         vld_p1      <= 1'b0;
         rdata_p1    <= '0;
         err_p1      <= OK;
         init_done_q <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               init_idx <= init_idx + 1'b1;
               if (init_idx == WW'(DEPTH_WORDS - 1)) begin
                  state       <= IDLE;
                  req_ready_q <= 1'b1;
                  init_done_q <= 1'b1;
               end
            end
            IDLE: begin
               if (bus.req_valid) begin
                  state       <= WAIT;
                  req_ready_q <= 1'b0;
                  lat_cnt     <= 4'(LATENCY - 1);
                  err_p1      <= req_err;
                  rdata_p1    <= (bus.req_write || (req_err != OK)) ? '0 : ldata;
               end
            end
            WAIT: begin
               if (lat_cnt == 4'd0) begin
                  state  <= RESP;
                  vld_p1 <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  vld_p1      <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_rdata = rdata_p1;
   assign bus.rsp_err   = err_p1;
   assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Scoreboard bench for lsu_data_memory: directed vectors plus random traffic
// against a byte-array reference model.
module tb_lsu_data_memory;

   localparam int DEPTH   = 64;
   localparam int LAT     = 3;

   logic clk;
   logic reset;

   lsu_data_memory_if bus();

   lsu_data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  err;
      int          acc;
      bit          seen;
   } exp_t;

   exp_t     exp_q[$];
   logic [7:0] model_mem [DEPTH];
   int       checks = 0;
   int       errors = 0;
   int       cyc    = 0;
   int       rr_mode = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference rules written directly from the RV32I access definitions.
   function automatic logic [1:0] model_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
      int nb;
      if (w ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7)) return 2'd3;
      nb = 1 << f3[1:0];
      if ((a % nb) != 0) return 2'd1;
      if (a >= DEPTH) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      longint v;
      int nb;
      nb = 1 << f3[1:0];
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(model_mem[a + i]) << (8 * i);
      if (f3 < 4 && v[8*nb-1]) v -= (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic model_clear();
      foreach (model_mem[i]) model_mem[i] = 8'h00;
   endtask

   // Issue one request; expected response is pushed at the acceptance edge.
   task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit use_exp,
                        input logic [31:0] xdata, input logic [1:0] xerr);
      int n;
      exp_t e;
      logic [1:0] me;
      n = 0;
      @(posedge clk); #2;
      while (!bus.req_ready && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (!bus.req_ready) begin
         chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
         return;
      end
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      me = model_err(w, f3, a);
      e.err  = use_exp ? xerr : me;
      e.data = use_exp ? xdata : ((w || me != 0) ? 32'h0 : model_load(f3, a));
      e.seen = 1'b0;
      @(posedge clk); #1;
      e.acc = cyc;
      exp_q.push_back(e);
      if (w && me == 0)
         for (int i = 0; i < (1 << f3[1:0]); i++) model_mem[a + i] = 8'(d >> (8 * i));
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!bus.req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("init_cycles", n, 32'd16);
      chk("init_done", 32'(bus.init_done), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 32'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #2;
         case (rr_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
            default: bus.rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares the head of the scoreboard whenever a response is shown.
   always @(negedge clk) begin
      if (!reset) begin
         if (exp_q.size() != 0) begin
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (!bus.rsp_valid && cyc >= exp_q[0].acc + LAT)
               chk("rsp_late", 32'(bus.rsp_valid), 32'd1);
         end
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
               chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
               chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
               if (!exp_q[0].seen) begin
                  chk("rsp_latency", cyc, exp_q[0].acc + LAT);
                  exp_q[0].seen = 1'b1;
               end
               if (bus.rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      logic [31:0] a;
      logic [2:0]  f3;
      bit          w;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.rsp_ready  = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_init_done", 32'(bus.init_done), 32'd0);
      reset = 1'b0;
      wait_init();

      issue(0, 3'b010, 32'h3C, 32'h0, 1, 32'h0000_0000, 2'b00);
      issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 2'b00);
      issue(0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFF_FFDE, 2'b00);
      issue(0, 3'b100, 32'h13, 32'h0, 1, 32'h0000_00DE, 2'b00);
      issue(0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF_DEAD, 2'b00);
      issue(0, 3'b101, 32'h10, 32'h0, 1, 32'h0000_BEEF, 2'b00);
      issue(1, 3'b001, 32'h11, 32'h1235, 1, 32'h0, 2'b01);
      issue(0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 2'b00);
      issue(0, 3'b010, 32'h40, 32'h0, 1, 32'h0, 2'b10);
      issue(0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 2'b11);
      issue(1, 3'b011, 32'h00, 32'h5, 1, 32'h0, 2'b11);
      drain();

      // Hold the response off for four cycles; the monitor re-checks it each cycle.
      rr_mode = 2;
      issue(0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 2'b00);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      rr_mode = 0;
      drain();

      // Reset while the store sits in WAIT: no response, array re-cleared.
      issue(1, 3'b010, 32'h20, 32'h1234_5678, 1, 32'h0, 2'b00);
      @(posedge clk); #2;
      reset = 1'b1;
      exp_q.delete();
      model_clear();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      wait_init();
      issue(0, 3'b010, 32'h20, 32'h0, 1, 32'h0000_0000, 2'b00);
      issue(0, 3'b010, 32'h10, 32'h0, 1, 32'h0000_0000, 2'b00);
      drain();

      rr_mode = 1;
      for (int k = 0; k < 200; k++) begin
         w  = $urandom_range(0, 1);
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
         if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(DEPTH, 4 * DEPTH));
         if ($urandom_range(0, 19) == 0) a = $urandom;
         issue(w, f3, a, $urandom, 0, 32'h0, 2'b00);
      end
      rr_mode = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
